// File: rtl/apb_pkg.sv
// apb_pkg: shared state encoding and default bus widths for the APB config master.
//   apb_state_e : IDLE, SETUP, ACCESS, RESP
//   APB_ADDR_W  : default APB address width
//   APB_DATA_W  : default APB data width
package apb_pkg;
   typedef enum logic [1:0] {IDLE, SETUP, ACCESS, RESP} apb_state_e;
   localparam int APB_ADDR_W = 32;
   localparam int APB_DATA_W = 32;
endpackage

// File: rtl/apb_config_master.sv
// apb_config_master: single-outstanding APB3 requester bridging a valid/ready host port.
//   pclk, preset                        : clock, asynchronous active-high reset
//   req_valid/req_ready/req_write/
//   req_addr/req_wdata                  : host request channel
//   rsp_valid/rsp_ready/rsp_rdata/
//   rsp_err                             : host response channel
//   paddr/psel/penable/pwrite/pwdata    : APB3 requester drive
//   prdata/pready/pslverr               : APB3 completer response
// Optional build macro APB_MASTER_TIMEOUT_EN adds an ACCESS-phase wait limit of
// TIMEOUT_CYCLES cycles that ends the transfer with rsp_err=1.
module apb_config_master
   import apb_pkg::*;
#(
   parameter int ADDR_W         = APB_ADDR_W,
   parameter int DATA_W         = APB_DATA_W,
   parameter int TIMEOUT_CYCLES = 256
) (
   input  logic              pclk,
   input  logic              preset,
   input  logic              req_valid,
   output logic              req_ready,
   input  logic              req_write,
   input  logic [ADDR_W-1:0] req_addr,
   input  logic [DATA_W-1:0] req_wdata,
   output logic              rsp_valid,
   input  logic              rsp_ready,
   output logic [DATA_W-1:0] rsp_rdata,
   output logic              rsp_err,
   output logic [ADDR_W-1:0] paddr,
   output logic              psel,
   output logic              penable,
   output logic              pwrite,
   output logic [DATA_W-1:0] pwdata,
   input  logic [DATA_W-1:0] prdata,
   input  logic              pready,
   input  logic              pslverr
);
   apb_state_e        state_q, state_d;
   logic [ADDR_W-1:0] addr_q;
   logic [DATA_W-1:0] wdata_q, rdata_q;
   logic              write_q, err_q, timeout, done;
`ifdef APB_MASTER_TIMEOUT_EN
   localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);
   logic [CNT_W-1:0] cnt_q;
   // Fires on the TIMEOUT_CYCLES-th ACCESS cycle that still sees pready low.
   assign timeout = (state_q == ACCESS) && !pready && (cnt_q == CNT_W'(TIMEOUT_CYCLES - 1));
   always_ff @(posedge pclk or posedge preset)
      if (preset) cnt_q <= '0;
      else if (state_q == SETUP) cnt_q <= '0;
      else if (state_q == ACCESS && !pready) cnt_q <= cnt_q + CNT_W'(1);
`else
   // TIMEOUT_CYCLES is a positive limit, so this is constant 0: ACCESS waits for pready.
   assign timeout = (TIMEOUT_CYCLES < 0);
`endif
   assign done = (state_q == ACCESS) && (pready || timeout);
   always_comb begin
      state_d = (state_q == IDLE)   ? (req_valid ? SETUP : IDLE) :
                (state_q == SETUP)  ? ACCESS :
                (state_q == ACCESS) ? (done ? RESP : ACCESS) :
                                      (rsp_ready ? IDLE : RESP);
   end
   always_ff @(posedge pclk or posedge preset)
      if (preset) state_q <= IDLE;
      else state_q <= state_d;
   always_ff @(posedge pclk or posedge preset)
      if (preset) begin
         addr_q  <= '0;
         wdata_q <= '0;
         write_q <= 1'b0;
         rdata_q <= '0;
         err_q   <= 1'b0;
      end else begin
         if (state_q == IDLE && req_valid) begin
            addr_q  <= req_addr;
            write_q <= req_write;
            wdata_q <= req_write ? req_wdata : '0;
         end
         // Completion data is captured only on the pready (or timeout) cycle.
         if (done) begin
            err_q   <= pready ? pslverr : 1'b1;
            rdata_q <= (pready && !write_q && !pslverr) ? prdata : '0;
         end
      end
   assign req_ready = (state_q == IDLE);
   assign psel      = (state_q == SETUP) || (state_q == ACCESS);
   assign penable   = (state_q == ACCESS);
   assign rsp_valid = (state_q == RESP);
   assign paddr     = addr_q;
   assign pwrite    = write_q;
   assign pwdata    = wdata_q;
   assign rsp_rdata = rdata_q;
   assign rsp_err   = err_q;
endmodule

// File: tb/tb_apb_config_master.sv
// tb_apb_config_master: scoreboard bench for apb_config_master with a small APB completer model.
module tb_apb_config_master;
   logic        pclk, preset;
   logic        req_valid, req_ready, req_write;
   logic [31:0] req_addr, req_wdata;
   logic        rsp_valid, rsp_ready, rsp_err;
   logic [31:0] rsp_rdata;
   logic [31:0] paddr, pwdata, prdata;
   logic        psel, penable, pwrite, pready, pslverr;
   logic [31:0] mem [0:63];
   logic [7:0]  wcnt;
   int          wait_states;
   logic        err_inj, stuck;
   logic [32:0] sb_q [$];
   int          n_checks, n_errors;

   apb_config_master #(.ADDR_W(32), .DATA_W(32), .TIMEOUT_CYCLES(8)) dut (
      .pclk(pclk), .preset(preset),
      .req_valid(req_valid), .req_ready(req_ready), .req_write(req_write),
      .req_addr(req_addr), .req_wdata(req_wdata),
      .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err),
      .paddr(paddr), .psel(psel), .penable(penable), .pwrite(pwrite), .pwdata(pwdata),
      .prdata(prdata), .pready(pready), .pslverr(pslverr)
   );

   initial pclk = 1'b0;
   always #5 pclk = ~pclk;

   // Completer: pready rises after wait_states stalled ACCESS cycles; data/err are junk while stalled.
   assign pready  = !stuck && (int'(wcnt) >= wait_states);
   assign prdata  = pready ? mem[paddr[7:2]] : 32'hBAD0_BAD0;
   assign pslverr = pready ? err_inj : 1'b1;
   always @(posedge pclk) begin
      wcnt <= (psel && penable && !pready) ? wcnt + 8'd1 : 8'd0;
      if (psel && penable && pready && pwrite && !err_inj) mem[paddr[7:2]] = pwdata;
   end

   task automatic check(input string tag, input logic [63:0] act, input logic [63:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_errors++;
         $display("FAIL %s: got %0h expected %0h", tag, act, exp);
      end
   endtask

   // Caller is at a negedge with the DUT idle; returns at a negedge back in IDLE.
   task automatic run_txn(input logic w, input logic [31:0] a, input logic [31:0] d,
                          input logic [31:0] er, input logic ee, input int hold, input int exp_acc);
      int          acc;
      logic [32:0] snap;
      sb_q.push_back({ee, er});
      req_valid = 1'b1; req_write = w; req_addr = a; req_wdata = d;
      check("req_ready", req_ready, 1);
      @(negedge pclk);
      req_valid = 1'b0;
      check("setup_bus", {psel, penable, pwrite}, {2'b10, w});
      check("setup_paddr", paddr, a);
      check("setup_pwdata", pwdata, w ? d : 32'h0);
      @(negedge pclk);
      acc = 0;
      for (int i = 0; i < 2000 && psel; i++) begin
         acc++;
         check("access_penable", penable, 1);
         check("access_paddr", paddr, a);
         @(negedge pclk);
      end
      check("access_cycles", acc, exp_acc);
      check("rsp_valid", rsp_valid, 1);
      snap = {rsp_err, rsp_rdata};
      for (int i = 0; i < hold; i++) begin
         @(negedge pclk);
         check("hold_valid", {rsp_valid, req_ready}, 2'b10);
         check("hold_data", {rsp_err, rsp_rdata}, snap);
      end
      rsp_ready = 1'b1;
      if (sb_q.size() == 0) check("sb_empty", 1, 0);
      else check("rsp_data", {rsp_err, rsp_rdata}, sb_q.pop_front());
      @(negedge pclk);
      rsp_ready = 1'b0;
      check("back_idle", {req_ready, rsp_valid}, 2'b10);
   endtask

   initial begin
      int n;
      n_checks = 0; n_errors = 0;
      for (int i = 0; i < 64; i++) mem[i] = 32'h0;
      mem[11] = 32'h1;
      mem[4]  = 32'hDEAD_BEEF;
      preset = 1'b1; req_valid = 1'b0; req_write = 1'b0; req_addr = '0; req_wdata = '0;
      rsp_ready = 1'b0; wait_states = 0; err_inj = 1'b0; stuck = 1'b0;
      repeat (2) @(negedge pclk);
      check("rst_bus", {psel, penable, pwrite, rsp_valid, rsp_err}, 5'b0);
      check("rst_paddr", paddr, 0);
      check("rst_pwdata", pwdata, 0);
      check("rst_rdata", rsp_rdata, 0);
      preset = 1'b0;
      @(negedge pclk);
      check("rst_req_ready", req_ready, 1);

      run_txn(1'b1, 32'h08, 32'h20, 32'h0, 1'b0, 0, 1);
      run_txn(1'b0, 32'h08, 32'h0, 32'h20, 1'b0, 0, 1);
      run_txn(1'b0, 32'h2C, 32'h0, 32'h1, 1'b0, 0, 1);
      wait_states = 5;
      run_txn(1'b0, 32'h10, 32'h0, 32'hDEAD_BEEF, 1'b0, 0, 6);
      wait_states = 0; err_inj = 1'b1;
      run_txn(1'b0, 32'h08, 32'h0, 32'h0, 1'b1, 3, 1);
      err_inj = 1'b0;
      run_txn(1'b1, 32'h34, 32'hA5A5_0F0F, 32'h0, 1'b0, 1, 1);
      run_txn(1'b0, 32'h34, 32'h0, 32'hA5A5_0F0F, 1'b0, 0, 1);

      stuck = 1'b1;
`ifdef APB_MASTER_TIMEOUT_EN
      run_txn(1'b0, 32'h0C, 32'h0, 32'h0, 1'b1, 0, 8);
      n = 3;
`else
      n = 1000;
`endif
      req_valid = 1'b1; req_write = 1'b0; req_addr = 32'h0C;
      @(negedge pclk);
      req_valid = 1'b0;
      for (int i = 0; i < n; i++) begin
         @(negedge pclk);
         if (psel && penable) n--;
         i--;
         if (i + 1 >= n) break;
      end
      n = 0;
      for (int i = 0; i < 3; i++) if (psel && penable) n++;
      check("stuck_psel", n, 3);
      preset = 1'b1;
      #1;
      check("async_rst_bus", {psel, penable, rsp_valid}, 3'b0);
      @(negedge pclk);
      preset = 1'b0; stuck = 1'b0;
      check("post_rst_ready", req_ready, 1);
      n = 0;
      repeat (5) begin
         @(negedge pclk);
         if (rsp_valid) n++;
      end
      check("no_dropped_rsp", n, 0);
      run_txn(1'b1, 32'h30, 32'h1234_5678, 32'h0, 1'b0, 0, 1);
      run_txn(1'b0, 32'h30, 32'h0, 32'h1234_5678, 1'b0, 0, 1);
      check("sb_drained", sb_q.size(), 0);
      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end
endmodule
